// File: rtl/request_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : request_feeder
// Purpose  : Small request FIFO that hands {side, data} entries one at a time
//            to a downstream FSM using a rqst / confirm handshake. It waits for
//            the matching acknowledge, retries on timeout and drops an entry
//            once its retries are used up.
// Ports    : clk        - rising-edge clock
//            rst        - asynchronous active-low reset
//            push       - enqueue strobe
//            push_data  - 4-bit value to deliver
//            push_side  - target register (0 = left, 1 = right)
//            ack_left   - downstream acknowledge, left side
//            ack_right  - downstream acknowledge, right side
//            rqst       - one-cycle request pulse
//            confirm    - one-cycle confirm pulse
//            din        - head data while a delivery is in progress, else 0
//            full/empty - FIFO occupancy flags
//            count      - FIFO occupancy
//            busy       - delivery in progress (state is not IDLE)
//            err        - sticky: dropped entry, wrong-side ack or overflow
// Revision : 1.0 - initial release
// ============================================================================
module request_feeder #(
  parameter int DEPTH     = 4,
  parameter int TIMEOUT   = 15,
  parameter int MAX_RETRY = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [3:0]               push_data,
  input  logic                     push_side,
  input  logic                     ack_left,
  input  logic                     ack_right,
  output logic                     rqst,
  output logic                     confirm,
  output logic [3:0]               din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT > 1)   ? $clog2(TIMEOUT + 1)   : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    CONF     = 2'd2,
    WAIT_ACK = 2'd3
  } state_t;

  state_t          state, state_nx;
  logic [TW-1:0]   timer, timer_nx;
  logic [RW-1:0]   retry, retry_nx;
  logic [4:0]      mem [DEPTH];
  logic [AW-1:0]   head, tail;
  logic [4:0]      head_entry;
  logic            push_ok;
  logic            overflow;
  logic            pop;
  logic            fsm_err;
  logic            ack_match;
  logic            ack_any;

  assign head_entry = mem[head];
  assign push_ok    = push && !full;
  assign overflow   = push && full;
  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);

  // Exactly one ack, on the side the head entry targets. Both acks high at
  // once is treated as a wrong-side acknowledge.
  assign ack_any    = ack_left || ack_right;
  assign ack_match  = head_entry[4] ? (ack_right && !ack_left)
                                    : (ack_left && !ack_right);

  // --------------------------------------------------------------------------
  // FIFO storage: data array is not reset; pointers and count define validity.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[tail] <= {push_side, push_data};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_ok) begin
        tail <= tail + AW'(1);
      end
      if (pop) begin
        head <= head + AW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Delivery FSM: next state, timer/retry bookkeeping and pop decision.
  // The timeout fires on the TIMEOUT-th WAIT_ACK cycle, so a retried entry
  // sees rqst pulses TIMEOUT+2 cycles apart (REQ + CONF + TIMEOUT waits).
  // --------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    timer_nx = timer;
    retry_nx = retry;
    pop      = 1'b0;
    fsm_err  = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          state_nx = REQ;
        end
      end
      REQ: begin
        state_nx = CONF;
      end
      CONF: begin
        state_nx = WAIT_ACK;
        timer_nx = '0;
      end
      WAIT_ACK: begin
        if (ack_match) begin
          pop      = 1'b1;
          retry_nx = '0;
          state_nx = IDLE;
        end else if (ack_any) begin
          pop      = 1'b1;
          fsm_err  = 1'b1;
          retry_nx = '0;
          state_nx = IDLE;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          if (retry == RW'(MAX_RETRY)) begin
            pop      = 1'b1;
            fsm_err  = 1'b1;
            retry_nx = '0;
            state_nx = IDLE;
          end else begin
            retry_nx = retry + RW'(1);
            state_nx = REQ;
          end
        end else begin
          timer_nx = timer + TW'(1);
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // state they describe. The head does not move until the pop that returns
  // the FSM to IDLE, so mem[head] is the right data whenever next != IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      timer   <= '0;
      retry   <= '0;
      err     <= 1'b0;
      rqst    <= 1'b0;
      confirm <= 1'b0;
      busy    <= 1'b0;
      din     <= '0;
    end else begin
      state   <= state_nx;
      timer   <= timer_nx;
      retry   <= retry_nx;
      err     <= err | overflow | fsm_err;
      rqst    <= (state_nx == REQ);
      confirm <= (state_nx == CONF);
      busy    <= (state_nx != IDLE);
      din     <= (state_nx != IDLE) ? head_entry[3:0] : 4'd0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_request_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_request_feeder
// Purpose  : Self-checking bench for request_feeder. Stimulus queues entries
//            together with the downstream behaviour wanted for each; a
//            responder plays the downstream FSM and a monitor checks every
//            cycle of each delivery against the expected entry.
// Revision : 1.0 - initial release
// ============================================================================
module tb_request_feeder;

  localparam int DEPTH     = 4;
  localparam int TIMEOUT   = 15;
  localparam int MAX_RETRY = 3;
  localparam int K_MATCH   = 0;   // ack the right side on attempt k
  localparam int K_WRONG   = 1;   // wrong-side (or both) ack on attempt k
  localparam int K_NONE    = 2;   // never ack, entry gets dropped

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       push = 1'b0;
  logic [3:0] push_data = 4'd0;
  logic       push_side = 1'b0;
  logic       ack_left = 1'b0;
  logic       ack_right = 1'b0;
  logic       rqst, confirm, full, empty, busy, err;
  logic [3:0] din;
  logic [$clog2(DEPTH):0] count;

  typedef struct {
    logic [3:0] data;
    logic       side;
    int         kind;
    int         k;
    bit         both;
  } entry_t;

  entry_t exp_q[$];
  entry_t pol_q[$];
  int     tests = 0;
  int     fails = 0;
  int     n_acc = 0;
  int     n_comp = 0;
  bit     ovf_seen = 1'b0;
  bit     err_acc = 1'b0;

  request_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .rst(rst), .push(push), .push_data(push_data),
    .push_side(push_side), .ack_left(ack_left), .ack_right(ack_right),
    .rqst(rqst), .confirm(confirm), .din(din), .full(full), .empty(empty),
    .count(count), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Monitor: one delivery = one busy interval; compares against the queue head.
  initial begin
    int     cyc;
    int     cur_rq;
    int     last_rq;
    bit     prev_rq;
    bit     prev_busy;
    bit     have_cur;
    entry_t cur;
    cyc = 0; cur_rq = 0; last_rq = 0; prev_rq = 0; prev_busy = 0; have_cur = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_rq = 0; prev_busy = 0; have_cur = 0; err_acc = 0; cyc = 0; cur_rq = 0;
      end else begin
        cyc++;
        if (busy && !prev_busy) begin
          chk("rqst_at_start", int'(rqst), 1);
          if (exp_q.size() == 0) begin
            tests++; fails++; have_cur = 0;
            $display("FAIL unexpected_delivery: busy=1 with din=%0d, expected no pending entry", din);
          end else begin
            cur = exp_q[0]; have_cur = 1;
          end
          cur_rq = 0;
        end
        chk("confirm_after_rqst", int'(confirm), int'(prev_rq));
        if (busy && have_cur) chk("din_busy", int'(din), int'(cur.data));
        else if (!busy)       chk("din_idle", int'(din), 0);
        if (rqst) begin
          cur_rq++;
          if (cur_rq > 1) chk("rqst_gap", cyc - last_rq, TIMEOUT + 2);
          last_rq = cyc;
        end
        if (!busy && prev_busy && have_cur) begin
          exp_q.delete(0);
          n_comp++;
          have_cur = 0;
          chk("rqst_pulses", cur_rq, (cur.kind == K_NONE) ? MAX_RETRY + 1 : cur.k);
          if (cur.kind != K_MATCH) err_acc = 1;
          chk("err_after_entry", int'(err), int'(err_acc || ovf_seen));
        end
        prev_rq = rqst;
        prev_busy = busy;
      end
    end
  end

  // Responder: plays the downstream FSM according to each entry's policy.
  initial begin
    int     attempt;
    bit     pend;
    entry_t e;
    attempt = 0; pend = 0;
    forever begin
      @(negedge clk);
      ack_left = 1'b0;
      ack_right = 1'b0;
      if (!rst) begin
        attempt = 0; pend = 0;
      end else if (pend && pol_q.size() > 0) begin
        e = pol_q[0];
        if (e.kind == K_MATCH) begin
          if (e.side) ack_right = 1'b1; else ack_left = 1'b1;
        end else if (e.both) begin
          ack_left = 1'b1; ack_right = 1'b1;
        end else begin
          if (e.side) ack_left = 1'b1; else ack_right = 1'b1;
        end
        pol_q.delete(0);
        pend = 0; attempt = 0;
      end else if (confirm && pol_q.size() > 0) begin
        attempt++;
        if (pol_q[0].kind != K_NONE && attempt == pol_q[0].k) begin
          pend = 1;
        end else if (attempt == MAX_RETRY + 1) begin
          pol_q.delete(0);
          attempt = 0;
        end
      end else if (rqst && $urandom_range(3) == 0) begin
        // Stray ack during REQ must be ignored.
        if ($urandom_range(1) == 1) ack_left = 1'b1; else ack_right = 1'b1;
      end
    end
  end

  task automatic do_push(input logic [3:0] d, input logic s, input int kind,
                         input int k, input bit both);
    entry_t e;
    bit     acc;
    e = '{d, s, kind, k, both};
    acc = (n_acc - n_comp) < DEPTH;
    push = 1'b1; push_data = d; push_side = s;
    @(posedge clk); #1;
    push = 1'b0;
    if (acc) begin
      exp_q.push_back(e); pol_q.push_back(e); n_acc++;
    end else begin
      ovf_seen = 1'b1;
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(posedge clk); #1; n++;
    end
    if (n >= budget) begin
      tests++; fails++;
      $display("FAIL drain_timeout: %0d entries pending after %0d cycles, expected 0", exp_q.size(), budget);
    end
  endtask

  initial begin
    int r;
    int kind;
    int w;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rqst", int'(rqst), 0);
    chk("rst_confirm", int'(confirm), 0);
    chk("rst_din", int'(din), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_count", int'(count), 0);
    chk("rst_err", int'(err), 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Single left entry, acked right after confirm; two-cycle latency
    do_push(4'd5, 1'b0, K_MATCH, 1, 1'b0);
    chk("count_after_push", int'(count), 1);
    @(negedge clk); chk("no_rqst_in_push_cycle", int'(rqst), 0);
    @(negedge clk); chk("rqst_latency", int'(rqst), 1);
    wait_drain(200);
    chk("t1_count", int'(count), 0);
    chk("t1_err", int'(err), 0);
    chk("t1_busy", int'(busy), 0);

    // Fill to DEPTH, then overflow push
    do_push(4'd3, 1'b0, K_MATCH, 1, 1'b0);
    do_push(4'd7, 1'b1, K_MATCH, 1, 1'b0);
    do_push(4'd9, 1'b0, K_MATCH, 1, 1'b0);
    do_push(4'd12, 1'b1, K_MATCH, 1, 1'b0);
    chk("full_after_4", int'(full), 1);
    do_push(4'd1, 1'b0, K_MATCH, 1, 1'b0);
    chk("err_after_overflow", int'(err), 1);
    wait_drain(400);
    chk("t2_count", int'(count), 0);

    // Never acknowledged: retried then dropped
    do_push(4'd6, 1'b1, K_NONE, 0, 1'b0);
    wait_drain(400);
    chk("t3_count", int'(count), 0);
    chk("t3_err", int'(err), 1);

    // Wrong-side ack, then a normal entry after one retry
    do_push(4'd2, 1'b1, K_WRONG, 1, 1'b0);
    do_push(4'd10, 1'b0, K_MATCH, 2, 1'b0);
    wait_drain(400);
    chk("t4_count", int'(count), 0);
    chk("t4_empty", int'(empty), 1);

    // Randomized traffic: pointers wrap many times, pushes overlap pops
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(2)) begin @(posedge clk); #1; end
      w = 0;
      while ((n_acc - n_comp) >= DEPTH && w < 1000) begin @(posedge clk); #1; w++; end
      r = $urandom_range(9);
      kind = (r < 6) ? K_MATCH : (r < 8) ? K_WRONG : K_NONE;
      do_push(4'($urandom_range(15)), 1'($urandom_range(1)), kind,
              $urandom_range(MAX_RETRY + 1, 1), 1'($urandom_range(1)));
    end
    wait_drain(6000);
    chk("rand_count", int'(count), 0);
    chk("rand_empty", int'(empty), 1);

    // Asynchronous reset in WAIT_ACK with three entries queued
    do_push(4'd4, 1'b0, K_NONE, 0, 1'b0);
    do_push(4'd8, 1'b1, K_NONE, 0, 1'b0);
    do_push(4'd13, 1'b0, K_NONE, 0, 1'b0);
    w = 0;
    @(negedge clk);
    while (!confirm && w < 50) begin @(negedge clk); w++; end
    chk("saw_confirm_before_reset", int'(confirm), 1);
    @(negedge clk);
    chk("busy_before_reset", int'(busy), 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_rqst", int'(rqst), 0);
    chk("arst_confirm", int'(confirm), 0);
    chk("arst_din", int'(din), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_count", int'(count), 0);
    chk("arst_empty", int'(empty), 1);
    chk("arst_err", int'(err), 0);
    exp_q.delete(); pol_q.delete();
    n_acc = 0; n_comp = 0; ovf_seen = 1'b0;
    @(negedge clk); @(negedge clk);
    #2 rst = 1'b1;
    do_push(4'd11, 1'b1, K_MATCH, 1, 1'b0);
    chk("push_first_edge_after_rst", int'(count), 1);
    wait_drain(200);
    chk("t6_count", int'(count), 0);
    chk("t6_err", int'(err), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
